// File: rtl/debounce_sync_if.sv
// Signal bundle between the raw-input conditioning stage and its consumer.
interface debounce_sync_if;
    logic raw_i;
    logic en_i;
    logic d_o;
    logic rise_o;
    logic fall_o;
    logic busy_o;

    modport slave (
        input  raw_i,
        input  en_i,
        output d_o,
        output rise_o,
        output fall_o,
        output busy_o
    );

    modport master (
        output raw_i,
        output en_i,
        input  d_o,
        input  rise_o,
        input  fall_o,
        input  busy_o
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchronises an asynchronous level and accepts a change only after it
// has held for STABLE_CYCLES consecutive clocks; emits one-cycle edge pulses.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    debounce_sync_if.slave  bus
);

    typedef enum logic {IDLE, CHECK} state_e;

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dval_q, dval_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            state_q <= IDLE;
            cnt_q   <= '0;
            dval_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dval_q  <= dval_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dval_d  = dval_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.en_i && (s != dval_q)) begin
                    state_d = CHECK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            CHECK: begin
                if (!bus.en_i || (s == dval_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_C) begin
                    // Accept the change; the pulse lands with the new level.
                    dval_d  = s;
                    rise_d  = s;
                    fall_d  = ~s;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == CHECK);
    end

    assign bus.d_o    = dval_q;
    assign bus.rise_o = rise_q;
    assign bus.fall_o = fall_q;
    assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench: hand-computed per-edge expectations for a STABLE_CYCLES=4
// instance plus a STABLE_CYCLES=1 instance for the minimum-count boundary.
module tb_debounce_sync;

    logic clk;
    logic rst_n;
    logic raw;
    logic en;
    int   n_chk = 0;
    int   n_err = 0;

    debounce_sync_if bus4 ();
    debounce_sync_if bus1 ();

    assign bus4.raw_i = raw;
    assign bus4.en_i  = en;
    assign bus1.raw_i = raw;
    assign bus1.en_i  = en;

    debounce_sync #(
        .SYNC_STAGES  (2),
        .CNT_W        (3),
        .STABLE_CYCLES(4),
        .RESET_VAL    (1'b0)
    ) dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus4)
    );

    debounce_sync #(
        .SYNC_STAGES  (2),
        .CNT_W        (3),
        .STABLE_CYCLES(1),
        .RESET_VAL    (1'b0)
    ) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, d, rise, fall}
    function automatic logic [3:0] vec(input logic b, input logic d, input logic r, input logic f);
        return {b, d, r, f};
    endfunction

    function automatic logic [3:0] obs4();
        return {bus4.busy_o, bus4.d_o, bus4.rise_o, bus4.fall_o};
    endfunction

    initial begin
        rst_n = 1'b1;
        raw   = 1'b1;
        en    = 1'b1;

        // 1: reset asserted between edges, raw high, clock running
        #2 rst_n = 1'b0;
        #1 check("reset_async", 32'(obs4()), 32'(vec(0, 0, 0, 0)));
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("reset_hold%0d", k), 32'(obs4()), 32'(vec(0, 0, 0, 0)));
        end
        raw = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", 32'(obs4()), 32'(vec(0, 0, 0, 0)));
        check("post_reset_idle1", 32'({bus1.d_o, bus1.busy_o}), 32'(2'b00));

        // 2: clean rise; second instance shows the one-cycle count
        raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rise_e%0d", k), 32'(obs4()),
                  32'(vec(k >= 2 && k <= 5, k >= 6, k == 6, 0)));
            check($sformatf("rise1_e%0d", k), 32'({bus1.d_o, bus1.rise_o, bus1.fall_o}),
                  32'({1'(k >= 3), 1'(k == 3), 1'b0}));
        end

        // clean fall back to 0
        raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("fall_e%0d", k), 32'(obs4()),
                  32'(vec(k >= 2 && k <= 5, k < 6, 0, k == 6)));
        end

        // 3: three-cycle glitch is rejected
        raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 2) raw = 1'b0;
            check($sformatf("glitch_e%0d", k), 32'(obs4()),
                  32'(vec(k >= 2 && k <= 4, 0, 0, 0)));
        end

        // 4: bounce 1,0,1,0,1 then held; edge 10 is 6 after the last transition
        for (int k = 0; k < 13; k++) begin
            if (k <= 4) raw = (k % 2 == 0);
            tick();
            check($sformatf("bounce_up_e%0d", k), 32'(obs4()),
                  32'(vec(k == 2 || k == 4 || (k >= 6 && k <= 9), k >= 10, k == 10, 0)));
        end
        for (int k = 0; k < 13; k++) begin
            if (k <= 4) raw = (k % 2 != 0);
            tick();
            check($sformatf("bounce_dn_e%0d", k), 32'(obs4()),
                  32'(vec(k == 2 || k == 4 || (k >= 6 && k <= 9), k < 10, 0, k == 10)));
        end

        // 5: enable dropped at count 2 for three edges forces a full recount
        raw = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 4) en = 1'b0;
            if (k == 7) en = 1'b1;
            tick();
            check($sformatf("enable_e%0d", k), 32'(obs4()),
                  32'(vec((k >= 2 && k <= 3) || (k >= 7 && k <= 10), k >= 11, k == 11, 0)));
        end

        raw = 1'b0;
        repeat (12) tick();
        check("pre_midreset", 32'(obs4()), 32'(vec(0, 0, 0, 0)));

        // 6: reset pulsed mid-count, pending change discarded
        raw = 1'b1;
        repeat (5) tick();
        check("count3_busy", 32'(obs4()), 32'(vec(1, 0, 0, 0)));
        #2 rst_n = 1'b0;
        #1 check("midreset_async", 32'(obs4()), 32'(vec(0, 0, 0, 0)));
        repeat (2) tick();
        check("midreset_hold", 32'(obs4()), 32'(vec(0, 0, 0, 0)));
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("recount_e%0d", k), 32'(obs4()),
                  32'(vec(k >= 2 && k <= 5, k >= 6, k == 6, 0)));
        end

        // raw toggling every cycle never moves d_o
        for (int k = 0; k < 20; k++) begin
            raw = ~raw;
            tick();
            check($sformatf("toggle_e%0d", k), 32'({bus4.d_o, bus4.rise_o, bus4.fall_o}),
                  32'(3'b100));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
